// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Registered Y86-64 execute stage. Selects ALU operands,
//                performs add/sub/and/xor, maintains the condition codes,
//                evaluates jump/cmov conditions and loads the E/M pipeline
//                register under stall/bubble control.
//                Optional: define EXEC_MISPRED_CNT_EN to add a saturating
//                count of not-taken conditional jumps (mispred_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int EXEC_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E_valid,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [EXEC_W-1:0] E_valA,
    input  logic [EXEC_W-1:0] E_valB,
    input  logic [EXEC_W-1:0] E_valC,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic              stall,
    input  logic              bubble,
    input  logic              set_cc_block,
    output logic              M_valid,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [EXEC_W-1:0] M_valE,
    output logic [EXEC_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM,
    output logic              e_Cnd,
    output logic              cc_zf,
    output logic              cc_sf,
`ifdef EXEC_MISPRED_CNT_EN
    output logic [31:0]       mispred_cnt,
`endif
    output logic              cc_of
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] F_ADD    = 4'h0;
    localparam logic [3:0] F_SUB    = 4'h1;
    localparam logic [3:0] F_AND    = 4'h2;
    localparam logic [3:0] F_XOR    = 4'h3;
    localparam logic [3:0] C_RNONE  = 4'hF;
    localparam logic [EXEC_W-1:0] C_PLUS8  = EXEC_W'(8);
    localparam logic [EXEC_W-1:0] C_MINUS8 = -C_PLUS8;
    localparam int MSB = EXEC_W - 1;

    logic [EXEC_W-1:0] w_alu_a;
    logic [EXEC_W-1:0] w_alu_b;
    logic [EXEC_W-1:0] w_alu_r;
    logic [3:0]        w_alufun;
    logic              w_alu_ok;
    logic              w_of;
    logic              w_lt;
    logic              w_cond;
    logic [3:0]        w_dste;
    logic              w_load_bubble;
    logic              w_cc_we;

    // ALU operand A: register value, immediate, or stack-pointer step
    always_comb begin
        w_alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:              w_alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_valC;
            I_CALL, I_PUSHQ:              w_alu_a = C_MINUS8;
            I_RET, I_POPQ:                w_alu_a = C_PLUS8;
            default:                      w_alu_a = '0;
        endcase
    end

    // ALU operand B: valB for memory/stack/arith ops, zero for moves
    always_comb begin
        w_alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ:
                w_alu_b = E_valB;
            default:
                w_alu_b = '0;
        endcase
    end

    // ALU: only OPq selects a function; an unknown ifun yields 0 and no CC write
    always_comb begin
        w_alufun = (E_icode == I_OPQ) ? E_ifun : F_ADD;
        w_alu_ok = 1'b1;
        w_alu_r  = '0;
        w_of     = 1'b0;
        case (w_alufun)
            F_ADD: begin
                w_alu_r = w_alu_b + w_alu_a;
                w_of    = (w_alu_a[MSB] == w_alu_b[MSB]) && (w_alu_r[MSB] != w_alu_b[MSB]);
            end
            F_SUB: begin
                w_alu_r = w_alu_b - w_alu_a;
                w_of    = (w_alu_a[MSB] != w_alu_b[MSB]) && (w_alu_r[MSB] != w_alu_b[MSB]);
            end
            F_AND:   w_alu_r = w_alu_b & w_alu_a;
            F_XOR:   w_alu_r = w_alu_b ^ w_alu_a;
            default: w_alu_ok = 1'b0;
        endcase
    end

    // Branch/cmov condition evaluated against the current CC register
    always_comb begin
        w_lt   = cc_sf ^ cc_of;
        w_cond = 1'b0;
        case (E_ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = w_lt | cc_zf;
            4'h2:    w_cond = w_lt;
            4'h3:    w_cond = cc_zf;
            4'h4:    w_cond = ~cc_zf;
            4'h5:    w_cond = ~w_lt;
            4'h6:    w_cond = ~w_lt & ~cc_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign e_Cnd         = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) && w_cond;
    assign w_dste        = ((E_icode == I_RRMOVQ) && !e_Cnd) ? C_RNONE : E_dstE;
    assign w_load_bubble = bubble || !E_valid;
    assign w_cc_we       = E_valid && !stall && !bubble && !set_cc_block &&
                           (E_icode == I_OPQ) && w_alu_ok;

    // E/M pipeline register: stall holds, bubble/invalid loads a nop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_valid <= 1'b0;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= C_RNONE;
            M_dstM  <= C_RNONE;
        end else if (!stall) begin
            if (w_load_bubble) begin
                M_valid <= 1'b0;
                M_icode <= I_NOP;
                M_Cnd   <= 1'b0;
                M_valE  <= '0;
                M_valA  <= '0;
                M_dstE  <= C_RNONE;
                M_dstM  <= C_RNONE;
            end else begin
                M_valid <= 1'b1;
                M_icode <= E_icode;
                M_Cnd   <= e_Cnd;
                M_valE  <= w_alu_r;
                M_valA  <= E_valA;
                M_dstE  <= w_dste;
                M_dstM  <= E_dstM;
            end
        end
    end

    // Condition-code register, written only by a committing valid OPq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (w_cc_we) begin
            cc_zf <= (w_alu_r == '0);
            cc_sf <= w_alu_r[MSB];
            cc_of <= w_of;
        end
    end

`ifdef EXEC_MISPRED_CNT_EN
    logic w_mispred;
    assign w_mispred = !stall && !bubble && E_valid && (E_icode == I_JXX) && !e_Cnd;

    // Saturating count of not-taken jumps (always-taken predictor misses)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (w_mispred && (mispred_cnt != 32'hFFFF_FFFF)) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Self-checking bench for execute_stage: a behavioural model
//                compared every cycle plus directed literal expectations.
//                Covers mispred_cnt when EXEC_MISPRED_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        E_valid = 1'b0;
    logic [3:0]  E_icode = 4'h1;
    logic [3:0]  E_ifun = 4'h0;
    logic [63:0] E_valA = '0;
    logic [63:0] E_valB = '0;
    logic [63:0] E_valC = '0;
    logic [3:0]  E_dstE = 4'hF;
    logic [3:0]  E_dstM = 4'hF;
    logic        stall = 1'b0;
    logic        bubble = 1'b0;
    logic        set_cc_block = 1'b0;
    logic        M_valid, M_Cnd, e_Cnd, cc_zf, cc_sf, cc_of;
    logic [3:0]  M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
`ifdef EXEC_MISPRED_CNT_EN
    logic [31:0] mispred_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    execute_stage #(.EXEC_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_icode(E_icode),
        .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .stall(stall), .bubble(bubble),
        .set_cc_block(set_cc_block), .M_valid(M_valid), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
        .M_dstM(M_dstM), .e_Cnd(e_Cnd), .cc_zf(cc_zf), .cc_sf(cc_sf),
`ifdef EXEC_MISPRED_CNT_EN
        .mispred_cnt(mispred_cnt),
`endif
        .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] opa(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] vc);
        if (ic inside {4'h2, 4'h6})       return va;
        if (ic inside {4'h3, 4'h4, 4'h5}) return vc;
        if (ic inside {4'h8, 4'hA})       return 64'hFFFF_FFFF_FFFF_FFF8;
        if (ic inside {4'h9, 4'hB})       return 64'd8;
        return 64'd0;
    endfunction

    function automatic logic [63:0] opb(input logic [3:0] ic, input logic [63:0] vb);
        if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) return vb;
        return 64'd0;
    endfunction

    // Returns {cc_write, zf, sf, of, result}; overflow from a 65-bit exact sum
    function automatic logic [67:0] ev(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [63:0] a, input logic [63:0] b);
        logic [64:0] w;
        logic [63:0] r;
        logic        o;
        logic [3:0]  op;
        w  = '0;
        r  = '0;
        o  = 1'b0;
        op = (ic == 4'h6) ? fn : 4'h0;
        if (op == 4'h0) begin
            w = {b[63], b} + {a[63], a};
            r = w[63:0];
            o = w[64] ^ w[63];
        end else if (op == 4'h1) begin
            w = {b[63], b} - {a[63], a};
            r = w[63:0];
            o = w[64] ^ w[63];
        end else if (op == 4'h2) begin
            r = a & b;
        end else if (op == 4'h3) begin
            r = a ^ b;
        end
        return {(ic == 4'h6) && (fn < 4'd4), r == 64'd0, r[63], o, r};
    endfunction

    function automatic logic cnd(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return lt | zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    logic        m_valid, m_cnd, m_zf, m_sf, m_of;
    logic [3:0]  m_icode, m_dstE, m_dstM;
    logic [63:0] m_valE, m_valA;
    logic [31:0] m_cnt;
    logic [67:0] x_ev;
    logic        x_ecnd;

    assign x_ev   = ev(E_icode, E_ifun, opa(E_icode, E_valA, E_valC), opb(E_icode, E_valB));
    assign x_ecnd = (E_icode == 4'h2 || E_icode == 4'h7) && cnd(E_ifun, m_zf, m_sf, m_of);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_icode <= 4'h1; m_cnd <= 1'b0; m_valE <= '0; m_valA <= '0;
            m_dstE <= 4'hF; m_dstM <= 4'hF; m_zf <= 1'b1; m_sf <= 1'b0; m_of <= 1'b0; m_cnt <= '0;
        end else if (!stall) begin
            if (bubble || !E_valid) begin
                m_valid <= 1'b0; m_icode <= 4'h1; m_cnd <= 1'b0; m_valE <= '0; m_valA <= '0;
                m_dstE <= 4'hF; m_dstM <= 4'hF;
            end else begin
                m_valid <= 1'b1;
                m_icode <= E_icode;
                m_cnd   <= x_ecnd;
                m_valE  <= x_ev[63:0];
                m_valA  <= E_valA;
                m_dstE  <= (E_icode == 4'h2 && !x_ecnd) ? 4'hF : E_dstE;
                m_dstM  <= E_dstM;
                if (x_ev[67] && !set_cc_block) begin
                    m_zf <= x_ev[66]; m_sf <= x_ev[65]; m_of <= x_ev[64];
                end
                if (E_icode == 4'h7 && !x_ecnd && m_cnt != 32'hFFFF_FFFF)
                    m_cnt <= m_cnt + 32'd1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_M_valid", {63'd0, M_valid}, {63'd0, m_valid});
            chk("cyc_M_icode", {60'd0, M_icode}, {60'd0, m_icode});
            chk("cyc_M_Cnd",   {63'd0, M_Cnd},   {63'd0, m_cnd});
            chk("cyc_M_valE",  M_valE, m_valE);
            chk("cyc_M_valA",  M_valA, m_valA);
            chk("cyc_M_dstE",  {60'd0, M_dstE},  {60'd0, m_dstE});
            chk("cyc_M_dstM",  {60'd0, M_dstM},  {60'd0, m_dstM});
            chk("cyc_e_Cnd",   {63'd0, e_Cnd},   {63'd0, x_ecnd});
            chk("cyc_cc",      {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
`ifdef EXEC_MISPRED_CNT_EN
            chk("cyc_mispred", {32'd0, mispred_cnt}, {32'd0, m_cnt});
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic op(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                      input logic [63:0] vb, input logic [63:0] vc, input logic [3:0] de);
        @(negedge clk);
        #1;
        E_valid = 1'b1; E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = 4'hF; stall = 1'b0; bubble = 1'b0; set_cc_block = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_M_icode", {60'd0, M_icode}, 64'd1);
        chk("rst_M_dstE",  {60'd0, M_dstE}, 64'hF);
        chk("rst_cc",      {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        op(4'h6, 4'h3, 64'd4, 64'd11, 0, 4'h5); tick();
        chk("xor_valE", M_valE, 64'd15);
        chk("xor_cc",   {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
        op(4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h5); tick();
        chk("xor0_valE", M_valE, 64'd0);
        chk("xor0_zf",   {63'd0, cc_zf}, 64'd1);

        op(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 4'h5); tick();
        chk("sub_valE", M_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_cc",   {61'd0, cc_zf, cc_sf, cc_of}, 64'b001);
        op(4'h7, 4'h2, 0, 0, 64'h400, 4'hF); #1;
        chk("jl_eCnd", {63'd0, e_Cnd}, 64'd1);
        tick();

        op(4'h6, 4'h3, 64'd4, 64'd11, 0, 4'h5); tick();
        op(4'h2, 4'h1, 64'd42, 0, 0, 4'h3); tick();
        chk("cmovle_nt_dstE", {60'd0, M_dstE}, 64'hF);
        chk("cmovle_nt_Cnd",  {63'd0, M_Cnd}, 64'd0);
        chk("cmovle_valE",    M_valE, 64'd42);
        op(4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h5); tick();
        op(4'h2, 4'h1, 64'd42, 0, 0, 4'h3); tick();
        chk("cmovle_t_dstE", {60'd0, M_dstE}, 64'h3);

        op(4'h6, 4'h0, 64'd5, 64'd7, 0, 4'h5); set_cc_block = 1'b1; tick();
        chk("ccblk_valE", M_valE, 64'd12);
        chk("ccblk_cc",   {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        op(4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h5); stall = 1'b1; tick();
        chk("stall_valE", M_valE, 64'd12);
        chk("stall_cc",   {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        op(4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h5); stall = 1'b1; bubble = 1'b1; tick();
        chk("stbub_valid", {63'd0, M_valid}, 64'd1);
        op(4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h5); bubble = 1'b1; tick();
        chk("bub_icode", {60'd0, M_icode}, 64'd1);
        chk("bub_valid", {63'd0, M_valid}, 64'd0);
        chk("bub_dstE",  {60'd0, M_dstE}, 64'hF);
        op(4'h6, 4'h1, 64'd1, 64'd0, 0, 4'h5); E_valid = 1'b0; tick();

        op(4'h6, 4'h0, 64'd3, 64'd4, 0, 4'h5); tick();
        chk("add_valE", M_valE, 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valE",  M_valE, 64'd0);
        chk("arst_icode", {60'd0, M_icode}, 64'd1);
        chk("arst_zf",    {63'd0, cc_zf}, 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;

        op(4'h6, 4'h5, 64'd3, 64'd4, 0, 4'h5); tick();
        chk("badfn_valE", M_valE, 64'd0);
        op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 4'h5); tick();
        chk("addovf_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
        op(4'hA, 4'h0, 0, 64'h100, 0, 4'h4); tick();
        chk("push_valE", M_valE, 64'hF8);
        op(4'hB, 4'h0, 0, 64'h100, 0, 4'h4); tick();
        chk("pop_valE", M_valE, 64'h108);
        op(4'h3, 4'h0, 0, 64'h77, 64'h55, 4'h2); tick();
        chk("irmov_valE", M_valE, 64'h55);

        op(4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h5); tick();
        for (int i = 0; i < 3; i++) begin
            op(4'h7, 4'h4, 0, 0, 64'h40, 4'hF); tick();
            chk("jne_Cnd", {63'd0, M_Cnd}, 64'd0);
        end
        op(4'h7, 4'h4, 0, 0, 64'h40, 4'hF); stall = 1'b1; tick();
        op(4'h7, 4'h0, 0, 0, 64'h40, 4'hF); tick();
        chk("jmp_Cnd", {63'd0, M_Cnd}, 64'd1);
`ifdef EXEC_MISPRED_CNT_EN
        chk("mispred_cnt", {32'd0, mispred_cnt}, 64'd3);
`endif
        op(4'h1, 4'h0, 0, 0, 0, 4'hF); tick();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
